// File: rtl/mxv_tx_arbiter_if.sv
// Requester/UART-side bundle for the MxV TX arbiter.
interface mxv_tx_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]   REQ;
  logic [8*N_REQ-1:0] DATA_IN;
  logic [N_REQ-1:0]   LAST;
  logic [N_REQ-1:0]   GNT;
  logic [N_REQ-1:0]   ACK;
  logic [7:0]         DATATX;
  logic               TRANS;
  logic               BUSY;
  logic               FRAME_DONE;
  logic               FRAME_ABORT;

  // Requester side: offers bytes, observes grant/ack/UART strobe.
  modport master (
    output REQ, DATA_IN, LAST,
    input  GNT, ACK, DATATX, TRANS, BUSY, FRAME_DONE, FRAME_ABORT
  );

  // Arbiter side.
  modport slave (
    input  REQ, DATA_IN, LAST,
    output GNT, ACK, DATATX, TRANS, BUSY, FRAME_DONE, FRAME_ABORT
  );
endinterface

// File: rtl/mxv_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the UART TX, with built-in
// inter-byte pacing of BYTE_CYCLES clocks after every transmit strobe.
module mxv_tx_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned BYTE_CYCLES = 52083,
  parameter int unsigned CNT_W       = $clog2(BYTE_CYCLES)
) (
  input  logic            clk,
  input  logic            reset,
  mxv_tx_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [7:0]       data_q,  data_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [N_REQ-1:0] ack_q,   ack_d;
  logic             trans_q, trans_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             abort_q, abort_d;

  logic [7:0]       din [N_REQ];
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ptr_next;

  // Unpack the flat byte bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      din[i] = bus.DATA_IN[8*i +: 8];
    end
  end

  // Round-robin winner: first set REQ bit at or above ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % int'(N_REQ));
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Pointer moves past the owner whenever its frame ends (done or abort).
  assign ptr_next = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    trans_d = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          owner_d = win;
          gnt_d   = ONE_HOT0 << win;
          ack_d   = ONE_HOT0 << win;
          data_d  = din[win];
          last_d  = bus.LAST[win];
          trans_d = 1'b1;
        end
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ptr_d   = ptr_next;
            gnt_d   = '0;
          end else if (bus.REQ[owner_q]) begin
            state_d = SEND;
            data_d  = din[owner_q];
            last_d  = bus.LAST[owner_q];
            ack_d   = ONE_HOT0 << owner_q;
            trans_d = 1'b1;
          end else begin
            state_d = IDLE;
            abort_d = 1'b1;
            ptr_d   = ptr_next;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      trans_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      trans_q <= trans_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.GNT         = gnt_q;
  assign bus.ACK         = ack_q;
  assign bus.DATATX      = data_q;
  assign bus.TRANS       = trans_q;
  assign bus.BUSY        = busy_q;
  assign bus.FRAME_DONE  = done_q;
  assign bus.FRAME_ABORT = abort_q;

endmodule
